// File: rtl/shift_seq_ctrl_amisha.sv
// Two-requester round-robin arbiter feeding a WIDTH-bit MSB-first serializer.
// Each granted word is sent as one frame: WIDTH bit cycles, then one DONE cycle.
module shift_seq_ctrl_amisha #(
    parameter int WIDTH = 8
) (
    input  logic             clk_amisha,
    input  logic             reset_n_amisha,
    input  logic             req0_amisha,
    input  logic [WIDTH-1:0] data0_amisha,
    output logic             ack0_amisha,
    input  logic             req1_amisha,
    input  logic [WIDTH-1:0] data1_amisha,
    output logic             ack1_amisha,
    output logic             s_out_amisha,
    output logic             s_valid_amisha,
    output logic             owner_amisha,
    output logic             busy_amisha,
    output logic             done_amisha
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shift_reg;
    logic [CW-1:0]    bit_cnt;
    logic             prio;      // 1: requester 1 wins a tie
    logic             pick1;
    logic             any_req;
    logic [WIDTH-1:0] grant_word;

    // NOTE: every signal written in always_comb gets a default first, so no latch can be inferred.
    always_comb begin
        any_req    = req0_amisha | req1_amisha;
        pick1      = req1_amisha & (~req0_amisha | prio);
        grant_word = pick1 ? data1_amisha : data0_amisha;
    end

    // NOTE: sequential state uses non-blocking assignments only; pulse outputs default low each edge.
    always_ff @(posedge clk_amisha or negedge reset_n_amisha) begin
        if (!reset_n_amisha) begin
            state          <= IDLE;
            shift_reg      <= '0;
            bit_cnt        <= '0;
            prio           <= 1'b0;
            ack0_amisha    <= 1'b0;
            ack1_amisha    <= 1'b0;
            s_out_amisha   <= 1'b0;
            s_valid_amisha <= 1'b0;
            owner_amisha   <= 1'b0;
            busy_amisha    <= 1'b0;
            done_amisha    <= 1'b0;
        end else begin
            ack0_amisha <= 1'b0;
            ack1_amisha <= 1'b0;
            done_amisha <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state          <= SHIFT;
                        shift_reg      <= grant_word;
                        s_out_amisha   <= grant_word[WIDTH-1];
                        s_valid_amisha <= 1'b1;
                        bit_cnt        <= '0;
                        owner_amisha   <= pick1;
                        prio           <= ~pick1;
                        ack0_amisha    <= ~pick1;
                        ack1_amisha    <= pick1;
                        busy_amisha    <= 1'b1;
                    end
                end
                SHIFT: begin
                    // s_out already shows the current MSB; stage the next one.
                    shift_reg <= {shift_reg[WIDTH-2:0], 1'b0};
                    bit_cnt   <= bit_cnt + 1'b1;
                    if (bit_cnt == LAST_BIT) begin
                        state          <= DONE;
                        s_valid_amisha <= 1'b0;
                        s_out_amisha   <= 1'b0;
                        done_amisha    <= 1'b1;
                    end else begin
                        s_out_amisha <= shift_reg[WIDTH-2];
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy_amisha <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
